// File: rtl/booth_mult_r4_hs.sv
// booth_mult_r4_hs
// Radix-4 sequential Booth multiplier with valid/ready handshakes on both
// sides. Each operand is sign- or zero-extended to E = WIDTH+2 bits, so that
// unsigned operands are treated as positive signed values. The product is
// then E/2 recoded steps of a signed multiply.
//
// Parameters
//   WIDTH    operand width in bits (even, >= 4)
//   ISOLATE  1: operands are captured in a 1-deep stage before the core
//            0: the core loads straight from the input ports
//
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   flush         synchronous abort of the staged and in-flight operations
//   in_valid      operands and sign_mode are valid
//   in_ready      block accepts operands this cycle
//   multiplicand  operand A (WIDTH)
//   multiplier    operand B (WIDTH)
//   sign_mode     [1]=A signed, [0]=B signed
//   out_valid     product valid, held until out_ready
//   out_ready     consumer accepts the product
//   product       A*B (2*WIDTH)
//   busy          stage or core holds an operation
module booth_mult_r4_hs #(
    parameter int WIDTH   = 8,
    parameter int ISOLATE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [1:0]           sign_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int E    = WIDTH + 2;
    localparam int ITER = E / 2;
    localparam int CW   = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [E-1:0]       a_q, a_d;
    logic [E:0]         hi_q, hi_d;
    logic [E-1:0]       lo_q, lo_d;
    logic               qm1_q, qm1_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               rdy_en_q, rdy_en_d;

    logic               core_idle;
    logic               ld_go;
    logic [WIDTH-1:0]   ld_a, ld_b;
    logic [1:0]         ld_mode;
    logic               stage_full;

    function automatic logic [E-1:0] ext(input logic [WIDTH-1:0] v, input logic s);
        ext = {{2{s & v[WIDTH-1]}}, v};
    endfunction

    assign core_idle = (state_q == S_IDLE);

    generate
        if (ISOLATE != 0) begin : g_iso
            logic               stage_full_q, stage_full_d;
            logic [WIDTH-1:0]   stage_a_q, stage_a_d;
            logic [WIDTH-1:0]   stage_b_q, stage_b_d;
            logic [1:0]         stage_mode_q, stage_mode_d;

            always_comb begin
                stage_full_d = stage_full_q;
                stage_a_d    = stage_a_q;
                stage_b_d    = stage_b_q;
                stage_mode_d = stage_mode_q;
                if (flush) begin
                    stage_full_d = 1'b0;
                end else if (in_valid && in_ready) begin
                    stage_full_d = 1'b1;
                    stage_a_d    = multiplicand;
                    stage_b_d    = multiplier;
                    stage_mode_d = sign_mode;
                end else if (stage_full_q && core_idle) begin
                    // Contents move into the core on this edge.
                    stage_full_d = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_full_q <= 1'b0;
                    stage_a_q    <= '0;
                    stage_b_q    <= '0;
                    stage_mode_q <= '0;
                end else begin
                    stage_full_q <= stage_full_d;
                    stage_a_q    <= stage_a_d;
                    stage_b_q    <= stage_b_d;
                    stage_mode_q <= stage_mode_d;
                end
            end

            assign in_ready   = rdy_en_q & ~stage_full_q & ~flush;
            assign ld_go      = stage_full_q & core_idle & ~flush;
            assign ld_a       = stage_a_q;
            assign ld_b       = stage_b_q;
            assign ld_mode    = stage_mode_q;
            assign stage_full = stage_full_q;
        end else begin : g_direct
            assign in_ready   = rdy_en_q & core_idle & ~flush;
            assign ld_go      = in_valid & in_ready;
            assign ld_a       = multiplicand;
            assign ld_b       = multiplier;
            assign ld_mode    = sign_mode;
            assign stage_full = 1'b0;
        end
    endgenerate

    // One Booth step. The sum is formed one bit wider than the high half so
    // that adding +-2A can never wrap before the arithmetic shift.
    logic signed [E+1:0]   a1_sx, a2_sx, pp, sum;
    logic signed [2*E+2:0] shifted;
    logic [2*E+1:0]        step_acc;
    logic                  unused_top;

    assign a1_sx = {{2{a_q[E-1]}}, a_q};
    assign a2_sx = {a_q[E-1], a_q, 1'b0};

    always_comb begin
        pp = '0;
        case ({lo_q[1:0], qm1_q})
            3'b001, 3'b010: pp = a1_sx;
            3'b011:         pp = a2_sx;
            3'b100:         pp = -a2_sx;
            3'b101, 3'b110: pp = -a1_sx;
            default:        pp = '0;
        endcase
    end

    assign sum        = $signed({hi_q[E], hi_q}) + pp;
    assign shifted    = $signed({sum, lo_q, qm1_q}) >>> 2;
    // After the shift the top bit is only a copy of the sign.
    assign step_acc   = shifted[2*E+1:0];
    assign unused_top = shifted[2*E+2];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        qm1_d     = qm1_q;
        product_d = product_q;
        rdy_en_d  = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (ld_go) begin
                    a_d     = ext(ld_a, ld_mode[1]);
                    hi_d    = '0;
                    lo_d    = ext(ld_b, ld_mode[0]);
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                {hi_d, lo_d, qm1_d} = step_acc;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d   = S_DONE;
                    product_d = step_acc[2*WIDTH:1];
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort wins over everything; the last product stays visible.
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            qm1_q     <= 1'b0;
            product_q <= '0;
            rdy_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            qm1_q     <= qm1_d;
            product_q <= product_d;
            rdy_en_q  <= rdy_en_d;
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign product   = product_q;
    assign busy      = stage_full | ~core_idle;

endmodule

// File: tb/tb_booth_mult_r4_hs.sv
// tb_booth_mult_r4_hs
// Directed bench for booth_mult_r4_hs at WIDTH=8: one instance with the
// input stage (ISOLATE=1) and one without (ISOLATE=0). Covers reset values,
// latency, sign modes, overlap, backpressure, flush, mid-operation reset and
// a short run of random operands against a behavioural product.
module tb_booth_mult_r4_hs;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        iv0, ir0, ov0, or0, busy0, fl0;
    logic [7:0]  a0, b0;
    logic [1:0]  m0;
    logic [15:0] p0;

    logic        iv1, ir1, ov1, or1, busy1, fl1;
    logic [7:0]  a1, b1;
    logic [1:0]  m1;
    logic [15:0] p1;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    booth_mult_r4_hs #(.WIDTH(8), .ISOLATE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(fl0),
        .in_valid(iv0), .in_ready(ir0),
        .multiplicand(a0), .multiplier(b0), .sign_mode(m0),
        .out_valid(ov0), .out_ready(or0), .product(p0), .busy(busy0)
    );

    booth_mult_r4_hs #(.WIDTH(8), .ISOLATE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(fl1),
        .in_valid(iv1), .in_ready(ir1),
        .multiplicand(a1), .multiplier(b1), .sign_mode(m1),
        .out_valid(ov1), .out_ready(or1), .product(p1), .busy(busy1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] m);
        logic signed [17:0] ae, be;
        logic signed [35:0] p;
        ae = {{10{m[1] & a[7]}}, a};
        be = {{10{m[0] & b[7]}}, b};
        p  = ae * be;
        return p[15:0];
    endfunction

    // One operation on the staged instance; core is idle on entry.
    task automatic op1(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                       input logic [15:0] exp, input int hold, input string tag);
        int n;
        n = 0;
        while (!ir1 && n < 50) begin tick; n++; end
        chk({tag, "_in_ready"}, ir1, 1);
        a1 = a; b1 = b; m1 = m; iv1 = 1'b1;
        tick;
        iv1 = 1'b0;
        n = 0;
        while (!ov1 && n < 50) begin tick; n++; end
        chk({tag, "_latency"}, n, 6);
        chk({tag, "_product"}, p1, exp);
        $display("iso1 %s a=%h b=%h mode=%b product=%h latency=%0d", tag, a, b, m, p1, n);
        if (hold > 0) begin
            or1 = 1'b0;
            repeat (hold) tick;
            chk({tag, "_hold_valid"}, ov1, 1);
            chk({tag, "_hold_product"}, p1, exp);
            or1 = 1'b1;
        end
        tick;
        chk({tag, "_consumed"}, ov1, 0);
    endtask

    task automatic op0(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                       input logic [15:0] exp, input string tag);
        int n;
        n = 0;
        while (!ir0 && n < 50) begin tick; n++; end
        chk({tag, "_in_ready"}, ir0, 1);
        a0 = a; b0 = b; m0 = m; iv0 = 1'b1;
        tick;
        iv0 = 1'b0;
        n = 0;
        while (!ov0 && n < 50) begin tick; n++; end
        chk({tag, "_latency"}, n, 5);
        chk({tag, "_product"}, p0, exp);
        $display("iso0 %s a=%h b=%h mode=%b product=%h latency=%0d", tag, a, b, m, p0, n);
        tick;
        chk({tag, "_consumed"}, ov0, 0);
    endtask

    initial begin
        int  n;
        logic seen;
        logic [7:0] ra, rb;
        logic [1:0] rm;

        rst_n = 1'b0;
        iv0 = 0; or0 = 1; fl0 = 0; a0 = 0; b0 = 0; m0 = 0;
        iv1 = 0; or1 = 1; fl1 = 0; a1 = 0; b1 = 0; m1 = 0;

        // Reset values
        tick; tick;
        chk("rst_in_ready1", ir1, 0);
        chk("rst_out_valid1", ov1, 0);
        chk("rst_product1", p1, 16'h0000);
        chk("rst_busy1", busy1, 0);
        chk("rst_in_ready0", ir0, 0);
        rst_n = 1'b1;
        tick;
        chk("post_rst_in_ready1", ir1, 1);
        chk("post_rst_in_ready0", ir0, 1);

        // Direct-load instance
        op0(8'h80, 8'h80, 2'b11, 16'h4000, "d_m128sq");
        op0(8'hFF, 8'hFF, 2'b00, 16'hFE01, "d_ffuu");

        // Staged instance: sign modes
        op1(8'h80, 8'h80, 2'b11, 16'h4000, 0, "s_m128sq");
        op1(8'hFF, 8'hFF, 2'b00, 16'hFE01, 0, "s_ffuu");
        op1(8'hFF, 8'hFF, 2'b10, 16'hFF01, 0, "s_ffsu");
        op1(8'hFF, 8'hFF, 2'b01, 16'hFF01, 0, "s_ffus");
        op1(8'hFF, 8'hFF, 2'b11, 16'h0001, 1, "s_ffss");

        // Overlap with backpressure: 3*5 then -7*9
        or1 = 1'b0;
        a1 = 8'd3; b1 = 8'd5; m1 = 2'b11; iv1 = 1'b1;
        tick;
        chk("b2b_stage_full_ready", ir1, 0);
        tick;
        chk("b2b_transfer_ready", ir1, 1);
        chk("b2b_transfer_busy", busy1, 1);
        a1 = 8'hF9; b1 = 8'd9;
        tick;
        iv1 = 1'b0;
        chk("b2b_second_accepted", ir1, 0);
        n = 0;
        while (!ov1 && n < 50) begin tick; n++; end
        chk("b2b_first_valid", ov1, 1);
        chk("b2b_first_product", p1, 16'h000F);
        $display("iso1 b2b first product=%h", p1);
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("bp_valid", ov1, 1);
            chk("bp_product", p1, 16'h000F);
            chk("bp_in_ready", ir1, 0);
        end
        or1 = 1'b1;
        tick;
        chk("b2b_handshake", ov1, 0);
        n = 0;
        while (!ov1 && n < 50) begin tick; n++; end
        chk("b2b_second_latency", n, 6);
        chk("b2b_second_product", p1, 16'hFFC1);
        $display("iso1 b2b second product=%h latency=%0d", p1, n);
        tick;
        chk("b2b_second_consumed", ov1, 0);

        // Flush during CALC step 2
        a1 = 8'd7; b1 = 8'd7; m1 = 2'b00; iv1 = 1'b1;
        tick;
        iv1 = 1'b0;
        tick;
        tick;
        fl1 = 1'b1; iv1 = 1'b1; a1 = 8'd1; b1 = 8'd1;
        #1;
        chk("flush_in_ready", ir1, 0);
        tick;
        fl1 = 1'b0; iv1 = 1'b0;
        chk("flush_busy", busy1, 0);
        chk("flush_out_valid", ov1, 0);
        chk("flush_product_kept", p1, 16'hFFC1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (ov1) seen = 1'b1;
        end
        chk("flush_no_output", seen, 0);
        chk("flush_still_idle", busy1, 0);
        $display("iso1 flush done busy=%b", busy1);
        op1(8'd100, 8'hFD, 2'b11, 16'hFED4, 0, "s_100xm3");

        // Reset in the middle of CALC
        a1 = 8'h55; b1 = 8'h33; m1 = 2'b00; iv1 = 1'b1;
        tick;
        iv1 = 1'b0;
        tick; tick; tick;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", ov1, 0);
        chk("mid_rst_product", p1, 16'h0000);
        chk("mid_rst_busy", busy1, 0);
        chk("mid_rst_in_ready", ir1, 0);
        chk("mid_rst_product0", p0, 16'h0000);
        tick;
        rst_n = 1'b1;
        tick;
        chk("mid_rst_release_ready", ir1, 1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (ov1) seen = 1'b1;
        end
        chk("mid_rst_no_partial", seen, 0);
        $display("iso1 mid-op reset done");

        // Random operands, all modes, random backpressure
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rm = 2'($urandom_range(0, 3));
            op1(ra, rb, rm, model(ra, rb, rm), int'($urandom_range(0, 3)), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
